// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter: source indices, the
// queued entry layout and the IX write bundle it feeds.
package wb_port_arbiter_pkg;

  localparam int WB_NUM_SRC    = 4;
  localparam int WB_REG_WIDTH  = 5;
  localparam int WB_DATA_WIDTH = 32;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_LSD = 2'd1;
  localparam logic [1:0] WB_SRC_MUL = 2'd2;
  localparam logic [1:0] WB_SRC_DIV = 2'd3;

  typedef struct packed {
    logic [WB_REG_WIDTH-1:0]  rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_port_entry_t;

  typedef struct packed {
    logic                     wr_en;
    logic [WB_REG_WIDTH-1:0]  rd;
    logic [WB_DATA_WIDTH-1:0] wr_data;
  } wb_ix_inf_t;

  function automatic wb_ix_inf_t pack_wb_ix(logic wr_en, wb_port_entry_t e);
    wb_ix_inf_t b;
    b.wr_en   = wr_en;
    b.rd      = e.rd;
    b.wr_data = e.data;
    return b;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Completion-source handshakes and the registered write bundle towards IX.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = WB_NUM_SRC,
  parameter int REG_WIDTH  = WB_REG_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]                 src_valid;
  logic [NUM_SRC-1:0]                 src_ready;
  logic [NUM_SRC-1:0]                 src_wr_en;
  logic [NUM_SRC-1:0][REG_WIDTH-1:0]  src_rd;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data;

  logic                  wb_wr_en;
  logic [REG_WIDTH-1:0]  wb_rd;
  logic [DATA_WIDTH-1:0] wb_wr_data;
  logic [SRC_W-1:0]      wb_src;
  logic                  wb_idle;

  modport master (
    output src_valid, src_wr_en, src_rd, src_data,
    input  src_ready, wb_wr_en, wb_rd, wb_wr_data, wb_src, wb_idle
  );

  modport slave (
    input  src_valid, src_wr_en, src_rd, src_data,
    output src_ready, wb_wr_en, wb_rd, wb_wr_data, wb_src, wb_idle
  );

endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Per-source completion FIFO. The caller never pushes when full nor pops
// when empty; DEPTH must be a power of two so the pointers wrap naturally.
module wb_src_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_port_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: storage has no reset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin sharing of the register-file write port between the ALU, LSD,
// MUL and DIV completion streams, each buffered by its own small FIFO.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = WB_NUM_SRC,
  parameter int REG_WIDTH  = WB_REG_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int DEPTH      = 2
) (
  input  logic                clk,
  input  logic                rst,
  wb_port_arbiter_if.slave    bus
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [REG_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t             push_entry [NUM_SRC];
  entry_t             head       [NUM_SRC];
  logic [CNT_W-1:0]   count      [NUM_SRC];
  logic [NUM_SRC-1:0] src_ready;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] req;

  logic [SRC_W-1:0]      rr_ptr;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant_vld;
  logic                  wb_wr_en_q;
  logic [REG_WIDTH-1:0]  wb_rd_q;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic [SRC_W-1:0]      wb_src_q;

  function automatic logic [SRC_W-1:0] rr_index(logic [SRC_W-1:0] base, int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return s[SRC_W-1:0];
  endfunction

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    // Ready looks only at the registered count, so a full FIFO stays closed
    // even in the cycle it is being drained.
    assign src_ready[gi] = rst && (count[gi] != FULL);
    // Completions without a real register write are accepted and dropped.
    assign push[gi] = bus.src_valid[gi] && src_ready[gi] && bus.src_wr_en[gi]
                      && (bus.src_rd[gi] != '0);
    assign push_entry[gi] = '{rd: bus.src_rd[gi], data: bus.src_data[gi]};
    assign req[gi] = (count[gi] != '0);
    assign pop[gi] = grant_vld && (grant_idx == SRC_W'(gi));

    wb_src_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push[gi]),
      .push_entry (push_entry[gi]),
      .pop        (pop[gi]),
      .head       (head[gi]),
      .count      (count[gi])
    );
  end

  // Scan from the farthest candidate back to rr_ptr so the last hit wins,
  // which is the first requester at or after rr_ptr.
  always_comb begin
    // NOTE: defaults first so every path assigns the grant and no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req[rr_index(rr_ptr, k)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_index(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= '0;
      wb_wr_en_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_src_q   <= '0;
    end else begin
      wb_wr_en_q <= grant_vld;
      if (grant_vld) begin
        rr_ptr    <= rr_index(grant_idx, 1);
        wb_rd_q   <= head[grant_idx].rd;
        wb_data_q <= head[grant_idx].data;
        wb_src_q  <= grant_idx;
      end else begin
        wb_rd_q   <= '0;
        wb_data_q <= '0;
        wb_src_q  <= '0;
      end
    end
  end

  assign bus.src_ready  = src_ready;
  assign bus.wb_wr_en   = wb_wr_en_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_wr_data = wb_data_q;
  assign bus.wb_src     = wb_src_q;
  assign bus.wb_idle    = (req == '0) && !wb_wr_en_q;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the four execution-unit completion streams (ALU, LSD, MUL, DIV). Each source delivers results through a valid/ready handshake into its own small FIFO. A round-robin arbiter drains the FIFOs, at most one write per cycle, into a registered write bundle for IX. Simultaneous completions therefore stall or queue instead of colliding on the write port.

## Interface
Parameters:
- NUM_SRC, 4, number of completion sources; index 0=ALU, 1=LSD, 2=MUL, 3=DIV
- REG_WIDTH, 5, register index width
- DATA_WIDTH, 32, result width
- DEPTH, 2, entries per source FIFO (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low (0 = in reset)
- src_valid  in  NUM_SRC  source i presents a completion
- src_ready  out  NUM_SRC  source i completion accepted this cycle when valid&ready
- src_wr_en  in  NUM_SRC  completion carries a register write
- src_rd  in  NUM_SRC×REG_WIDTH  destination register per source
- src_data  in  NUM_SRC×DATA_WIDTH  result per source
- wb_wr_en  out  1  register-file write strobe (registered)
- wb_rd  out  REG_WIDTH  write index (registered)
- wb_wr_data  out  DATA_WIDTH  write data (registered)
- wb_src  out  2  source index of the current write, for debug/perf (registered)
- wb_idle  out  1  all FIFOs empty and wb_wr_en low

## Operation
- Handshake: a transfer occurs on source i in any cycle where src_valid[i] & src_ready[i]. src_ready[i] = (count[i] != DEPTH). It depends only on registered count, never on src_valid. A full FIFO holds ready low even in a cycle where it is being popped; there is no pop-through.
- Filtering: a transferred completion with src_wr_en=0 or src_rd=0 is accepted and discarded. It is not enqueued and consumes no arbitration slot.
- Enqueue: every other transfer writes {rd, data} at wr_ptr[i], increments wr_ptr[i] modulo DEPTH, and increments count[i].
- Arbitration: the request vector is req[i] = (count[i] != 0). Grant goes to the first requesting index at or after rr_ptr, searching cyclically.
  - On any grant g: rr_ptr ← (g+1) mod NUM_SRC, and FIFO g pops (rd_ptr[g]++, count[g]--).
  - With no requests, rr_ptr holds.
- Output register: each cycle wb_wr_en ← |req. When a grant exists, wb_rd, wb_wr_data and wb_src ← the granted head. When there is none, wb_rd, wb_wr_data and wb_src ← 0.
- Simultaneous push and pop on the same FIFO leaves count unchanged and advances both pointers.
- Ordering:
  - Completions from one source retire in acceptance order.
  - Across sources, order follows arbitration. IX issue guarantees no two in-flight writes to the same rd in different units.
- Fairness: a non-empty FIFO is granted within NUM_SRC cycles.
- wb_idle = (all count==0) & ~wb_wr_en.

## Timing
- Reset (rst=0, asynchronous): all counts, pointers and rr_ptr ← 0; wb_wr_en, wb_rd, wb_wr_data, wb_src ← 0. src_ready=0 while rst=0, and all 1 on the first cycle after release. wb_idle=1 after release.
- Latency: a transfer in cycle N produces wb_wr_en=1 in cycle N+2 at the earliest, i.e. when its FIFO is empty and it wins arbitration in N+1.
- Throughput: one write per cycle when any FIFO is non-empty.
- Reset asserted mid-operation drops all queued entries with no write emitted. FIFO storage is not reset; only pointers and counts are.
- Wrap-around: pointers wrap at DEPTH, and rr_ptr wraps 3→0.

## Structure
- Shared package (defines): add the WB_SRC_ALU/LSD/MUL/DIV index constants and a wb_port_entry_t struct {rd, data}. Reuse the existing REG_WIDTH and wb_ix_inf_t layout so the output can be packed directly into wb_ix_inf_t.
- Sub-module wb_src_fifo (parameterised DEPTH, entry type, push/pop/count/head). It is instantiated NUM_SRC times.
- The arbiter and the output register live in the top module.

## Test plan
- Single source: ALU sends rd=5, data=0xDEADBEEF in cycle 1. Expect wb_wr_en=1, wb_rd=5, wb_wr_data=0xDEADBEEF, wb_src=0 in cycle 3, and wb_idle=1 in cycle 4.
- Four-way collision: all sources valid in cycle 1 with rd=1..4 and rr_ptr=0. Expect writes rd=1,2,3,4 in cycles 3,4,5,6 and rr_ptr=0 afterwards.
- Backpressure: MUL valid every cycle with rd=7, while ALU and DIV are also valid every cycle and hold arbitration.
  - MUL src_ready drops once count=2.
  - No accepted MUL entry is lost or reordered; check against a scoreboard data sequence.
- Filtering: LSD sends src_wr_en=0 (rd=9) and then rd=0 with src_wr_en=1. Expect src_ready=1 for both, no wb_wr_en, and wb_idle stays 1.
- Full-with-pop: DIV FIFO full and granted in the same cycle DIV asserts valid. Expect src_ready[3]=0 that cycle and 1 the next.
- Mid-operation reset: three entries queued, then rst pulsed low for half a cycle asynchronously. Expect all outputs 0 immediately, no further writes, and src_ready=4'b1111 after release.
